// File: rtl/crossy_pkg.sv
// Shared constants for the PS/2 keyboard path: HID codes,
// scan-code set 2 values, frame FSM states and the translation table.
package crossy_pkg;

    localparam logic [7:0] KEY_NONE  = 8'h00;
    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_SPACE = 8'h2C;

    localparam logic [7:0] PS2_W     = 8'h1D;
    localparam logic [7:0] PS2_A     = 8'h1C;
    localparam logic [7:0] PS2_S     = 8'h1B;
    localparam logic [7:0] PS2_D     = 8'h23;
    localparam logic [7:0] PS2_SPACE = 8'h29;
    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } frame_state_t;

    function automatic logic [7:0] ps2_to_hid(input logic [7:0] code);
        case (code)
            PS2_W:     return KEY_W;
            PS2_A:     return KEY_A;
            PS2_S:     return KEY_S;
            PS2_D:     return KEY_D;
            PS2_SPACE: return KEY_SPACE;
            default:   return KEY_NONE;
        endcase
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame deserialiser: synchronisers, falling-edge
// detect, start/data/parity/stop FSM and a mid-frame inactivity timeout.
module ps2_frame_rx
    import crossy_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 10000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] data_byte,
    output logic       byte_valid,
    output logic       frame_err,
    output logic       timeout
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   clk_s;
    logic                   data_s;
    logic                   fall;

    frame_state_t state;
    logic [2:0]   count;
    logic [7:0]   shreg;
    logic         parity_ok;
    logic [TW-1:0] tcnt;

    assign clk_s  = clk_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];
    assign fall   = clk_prev & ~clk_s;

    // Presetting to the idle-high line level avoids a false edge out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= clk_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            count      <= 3'd0;
            shreg      <= 8'h00;
            parity_ok  <= 1'b0;
            tcnt       <= '0;
            data_byte  <= 8'h00;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            timeout    <= 1'b0;
            if (state != IDLE && !fall && tcnt == TW'(TIMEOUT_CYCLES)) begin
                state     <= IDLE;
                tcnt      <= '0;
                frame_err <= 1'b1;
                timeout   <= 1'b1;
            end else begin
                if (state == IDLE || fall)
                    tcnt <= '0;
                else
                    tcnt <= tcnt + 1'b1;
                if (fall) begin
                    unique case (state)
                        IDLE: begin
                            if (!data_s) begin
                                state <= DATA;
                                count <= 3'd0;
                            end
                        end
                        DATA: begin
                            shreg[count] <= data_s;
                            if (count == 3'd7)
                                state <= PARITY;
                            else
                                count <= count + 3'd1;
                        end
                        PARITY: begin
                            parity_ok <= ^{shreg, data_s};
                            state     <= STOP;
                        end
                        STOP: begin
                            state <= IDLE;
                            if (data_s && parity_ok) begin
                                data_byte  <= shreg;
                                byte_valid <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                            end
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard receiver: tracks make/break/extended prefixes and holds
// the HID code of the currently pressed mapped key on keycode.
module ps2_keycode_rx
    import crossy_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 10000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keycode,
    output logic       key_valid,
    output logic       frame_err
);

    logic [7:0] data_byte;
    logic       byte_valid;
    logic       timeout;
    logic       brk;
    logic       ext;
    logic [7:0] hid;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .SYNC_STAGES   (SYNC_STAGES)
    ) u_frame (
        .clk       (Clk),
        .rst       (Reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .data_byte (data_byte),
        .byte_valid(byte_valid),
        .frame_err (frame_err),
        .timeout   (timeout)
    );

    assign hid = ps2_to_hid(data_byte);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            keycode   <= KEY_NONE;
            key_valid <= 1'b0;
            brk       <= 1'b0;
            ext       <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (timeout) begin
                brk <= 1'b0;
                ext <= 1'b0;
            end else if (byte_valid) begin
                if (data_byte == PS2_EXT) begin
                    ext <= 1'b1;
                end else if (data_byte == PS2_BREAK) begin
                    brk <= 1'b1;
                end else begin
                    brk <= 1'b0;
                    ext <= 1'b0;
                    // Extended keys share base codes with mapped keys; skip them.
                    if (!ext && hid != KEY_NONE) begin
                        if (!brk) begin
                            if (hid != keycode) begin
                                keycode   <= hid;
                                key_valid <= 1'b1;
                            end
                        end else if (hid == keycode) begin
                            keycode   <= KEY_NONE;
                            key_valid <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Self-checking bench for ps2_keycode_rx: directed scenarios plus a
// randomized byte stream checked against a key-state reference model.
module tb_ps2_keycode_rx;

    localparam int HALF = 20;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] keycode;
    logic       key_valid;
    logic       frame_err;

    int total = 0;
    int bad = 0;
    int kv_cnt = 0;
    int fe_cnt = 0;
    int glitch = 0;
    logic [7:0] prev_key = 8'h00;

    bit [7:0] hid_map [256];
    logic [7:0] m_key = 8'h00;
    bit m_brk = 1'b0;
    bit m_ext = 1'b0;
    int m_kv = 0;
    int m_fe = 0;

    ps2_keycode_rx dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .keycode  (keycode),
        .key_valid(key_valid),
        .frame_err(frame_err)
    );

    always #10 Clk = ~Clk;

    always @(negedge Clk) begin
        if (!Reset) begin
            if (key_valid) kv_cnt++;
            if (frame_err) fe_cnt++;
            if (key_valid !== (keycode !== prev_key)) glitch++;
        end
        prev_key = keycode;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(posedge Clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(posedge Clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send(input logic [7:0] b, input bit bad_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
        ps2_bit(1'b1);
        ps2_data = 1'b1;
        repeat (8) @(posedge Clk);
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic [7:0] h;
        if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            h = hid_map[b];
            if (!m_ext && h != 8'h00) begin
                if (!m_brk && h != m_key) begin
                    m_key = h;
                    m_kv++;
                end else if (m_brk && h == m_key) begin
                    m_key = 8'h00;
                    m_kv++;
                end
            end
            m_brk = 1'b0;
            m_ext = 1'b0;
        end
    endtask

    task automatic tx(input logic [7:0] b, input bit bad_par);
        send(b, bad_par);
        if (bad_par) m_fe++;
        else model_byte(b);
    endtask

    task automatic verify(input string tag);
        check({tag, "_key"}, {24'd0, keycode}, {24'd0, m_key});
        check({tag, "_kv"}, kv_cnt, m_kv);
        check({tag, "_fe"}, fe_cnt, m_fe);
    endtask

    initial begin
        logic [7:0] pool [10];
        logic [7:0] b;
        bit e;

        hid_map[8'h1D] = 8'h1A;
        hid_map[8'h1C] = 8'h04;
        hid_map[8'h1B] = 8'h16;
        hid_map[8'h23] = 8'h07;
        hid_map[8'h29] = 8'h2C;
        pool = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h29,
                 8'hF0, 8'hF0, 8'hE0, 8'h75, 8'h11};

        repeat (3) @(posedge Clk);
        #1;
        check("rst_key", {24'd0, keycode}, 32'h0);
        check("rst_kv", {31'd0, key_valid}, 32'h0);
        check("rst_fe", {31'd0, frame_err}, 32'h0);
        @(negedge Clk);
        Reset = 1'b0;
        repeat (4) @(posedge Clk);

        tx(8'h1D, 1'b0); verify("w_make");
        tx(8'hF0, 1'b0); tx(8'h1D, 1'b0); verify("w_break");

        tx(8'h1C, 1'b0); verify("a_make");
        tx(8'h23, 1'b0); verify("d_make");
        for (int i = 0; i < 3; i++) tx(8'h23, 1'b0);
        verify("d_repeat");
        tx(8'hF0, 1'b0); tx(8'h1C, 1'b0); verify("a_break");

        tx(8'h1B, 1'b1); verify("s_badpar");
        tx(8'h1B, 1'b0); verify("s_make");

        tx(8'hE0, 1'b0); tx(8'h75, 1'b0); verify("ext_up");
        tx(8'h29, 1'b0); verify("space");

        tx(8'hE0, 1'b0);
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'(i & 1));
        ps2_data = 1'b1;
        repeat (10200) @(posedge Clk);
        m_fe++;
        m_brk = 1'b0;
        m_ext = 1'b0;
        verify("timeout");
        tx(8'h1D, 1'b0); verify("after_to");

        for (int n = 0; n < 40; n++) begin
            b = pool[$urandom_range(9)];
            e = ($urandom_range(7) == 0);
            tx(b, e);
            verify($sformatf("rnd%0d", n));
        end

        tx(8'h29, 1'b0); verify("pre_rst");
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        Reset = 1'b1;
        #1;
        check("mid_rst_key", {24'd0, keycode}, 32'h0);
        check("mid_rst_kv", {31'd0, key_valid}, 32'h0);
        check("mid_rst_fe", {31'd0, frame_err}, 32'h0);
        m_key = 8'h00;
        m_brk = 1'b0;
        m_ext = 1'b0;
        ps2_data = 1'b1;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        repeat (4) @(posedge Clk);
        tx(8'h1B, 1'b0); verify("post_rst");

        check("kv_tracks_key", glitch, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
